// File: rtl/ysyx_22040895_csr_file.sv
// Machine-mode CSR file for the ysyx_22040895 NPC core.
// It provides combinational CSR reads and commits writes, traps, mret and the cycle/instret counters.
module ysyx_22040895_csr_file #(
   parameter int               XLEN        = 64,
   parameter logic [XLEN-1:0]  MSTATUS_RST = 64'h0000_000a_0000_1800,
   parameter logic [XLEN-1:0]  MTVEC_RST   = 64'h0,
   parameter logic [XLEN-1:0]  MISA_VAL    = 64'h8000_0000_0000_0100
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     csr_raddr_i,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            csr_illegal_o,
   input  logic            csr_wen_i,
   input  logic [11:0]     csr_waddr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   input  logic            trap_en_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic            mret_en_i,
   input  logic            retire_i,
   output logic [XLEN-1:0] mepc_o,
   output logic [XLEN-1:0] mcause_o,
   output logic [XLEN-1:0] mtvec_o,
   output logic [XLEN-1:0] mstatus_o
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MISA     = 12'h301;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
   localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

   localparam logic [XLEN-1:0] MSTATUS_WMASK = {{(XLEN-13){1'b0}}, 13'h1888};
   localparam logic [XLEN-1:0] ONE           = {{(XLEN-1){1'b0}}, 1'b1};

   logic [XLEN-1:0] mstatus, mtvec, mscratch, mepc, mcause, mcycle, minstret;
   logic [XLEN-1:0] mstatus_next;
   logic            wen_mstatus, wen_mtvec, wen_mscratch, wen_mepc;
   logic            wen_mcause, wen_mcycle, wen_minstret;

   // A trap or mret only blocks a same-cycle write to the registers it updates itself.
   assign wen_mstatus  = csr_wen_i && (csr_waddr_i == ADDR_MSTATUS) && !trap_en_i && !mret_en_i;
   assign wen_mepc     = csr_wen_i && (csr_waddr_i == ADDR_MEPC)    && !trap_en_i;
   assign wen_mcause   = csr_wen_i && (csr_waddr_i == ADDR_MCAUSE)  && !trap_en_i;
   assign wen_mtvec    = csr_wen_i && (csr_waddr_i == ADDR_MTVEC);
   assign wen_mscratch = csr_wen_i && (csr_waddr_i == ADDR_MSCRATCH);
   assign wen_mcycle   = csr_wen_i && (csr_waddr_i == ADDR_MCYCLE);
   assign wen_minstret = csr_wen_i && (csr_waddr_i == ADDR_MINSTRET);

   // MPP is pinned to machine mode on every path since this core has no lower privilege.
   always_comb begin
      mstatus_next = mstatus;
      if (trap_en_i) begin
         mstatus_next[7] = mstatus[3];
         mstatus_next[3] = 1'b0;
      end else if (mret_en_i) begin
         mstatus_next[3] = mstatus[7];
         mstatus_next[7] = 1'b1;
      end else if (wen_mstatus) begin
         mstatus_next = (mstatus & ~MSTATUS_WMASK) | (csr_wdata_i & MSTATUS_WMASK);
      end
      mstatus_next[12:11] = 2'b11;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus  <= MSTATUS_RST;
         mtvec    <= MTVEC_RST;
         mscratch <= '0;
         mepc     <= '0;
         mcause   <= '0;
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         mstatus <= mstatus_next;
         if (trap_en_i) begin
            mepc   <= {trap_pc_i[XLEN-1:2], 2'b00};
            mcause <= trap_cause_i;
         end else begin
            if (wen_mepc)   mepc   <= {csr_wdata_i[XLEN-1:2], 2'b00};
            if (wen_mcause) mcause <= csr_wdata_i;
         end
         if (wen_mtvec)    mtvec    <= {csr_wdata_i[XLEN-1:2], 2'b00};
         if (wen_mscratch) mscratch <= csr_wdata_i;
         mcycle <= wen_mcycle ? csr_wdata_i : mcycle + ONE;
         if (wen_minstret)  minstret <= csr_wdata_i;
         else if (retire_i) minstret <= minstret + ONE;
      end
   end

   always_comb begin
      csr_rdata_o   = '0;
      csr_illegal_o = 1'b0;
      case (csr_raddr_i)
         ADDR_MSTATUS:  csr_rdata_o = mstatus;
         ADDR_MISA:     csr_rdata_o = MISA_VAL;
         ADDR_MTVEC:    csr_rdata_o = mtvec;
         ADDR_MSCRATCH: csr_rdata_o = mscratch;
         ADDR_MEPC:     csr_rdata_o = mepc;
         ADDR_MCAUSE:   csr_rdata_o = mcause;
         ADDR_MCYCLE:   csr_rdata_o = mcycle;
         ADDR_MINSTRET: csr_rdata_o = minstret;
         ADDR_MHARTID:  csr_rdata_o = '0;
         default:       csr_illegal_o = 1'b1;
      endcase
   end

   assign mepc_o    = mepc;
   assign mcause_o  = mcause;
   assign mtvec_o   = mtvec;
   assign mstatus_o = mstatus;

endmodule

// File: doc/ysyx_22040895_csr_file.md
Name: ysyx_22040895_csr_file

Overview:
Machine-mode CSR register file for the ysyx_22040895 NPC core. It sits directly upstream and downstream of the privileged execution unit. It supplies the current values of the addressed CSR, mepc, mcause, mtvec and mstatus to that unit, and commits the CSR write, trap (ecall) and mret updates that the unit produces. It also owns the free-running mcycle and minstret counters.

Parameters:
XLEN, 64, CSR data width
MSTATUS_RST, 64'h0000_000a_0000_1800, mstatus reset value (UXL/SXL=2, MPP=11)
MTVEC_RST, 64'h0, mtvec reset value
MISA_VAL, 64'h8000_0000_0000_0100, hard-wired misa (RV64I)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
csr_raddr_i  in  12  CSR read address
csr_rdata_o  out  XLEN  combinational read data for csr_raddr_i
csr_illegal_o  out  1  csr_raddr_i not implemented (combinational)
csr_wen_i  in  1  CSR write enable (csrrw/csrrs commit)
csr_waddr_i  in  12  CSR write address
csr_wdata_i  in  XLEN  full new value, already merged by the privileged unit
trap_en_i  in  1  ecall/exception commit
trap_cause_i  in  XLEN  value for mcause
trap_pc_i  in  XLEN  faulting PC for mepc
mret_en_i  in  1  mret commit
retire_i  in  1  one instruction retired this cycle
mepc_o  out  XLEN  current mepc
mcause_o  out  XLEN  current mcause
mtvec_o  out  XLEN  current mtvec
mstatus_o  out  XLEN  current mstatus

Behaviour:
- Map: mstatus 0x300, misa 0x301 (RO), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mhartid 0xF14 (RO, 0).
- Reset (rst=1 at posedge): mstatus=MSTATUS_RST, mtvec=MTVEC_RST, all other regs 0. All outputs reflect these values in the cycle after reset. Reset overrides every other input.
- Reads are combinational from the current register state. A write in the same cycle is visible only after the next posedge (read returns the old value). Unmapped address -> csr_rdata_o=0, csr_illegal_o=1.
- Write masks:
  - mstatus writable bits: MIE[3], MPIE[7], MPP[12:11]. MPP is always forced to 11 (M-only core). Other bits keep their current value.
  - mtvec: bits[1:0] are forced to 00 (direct mode only).
  - mepc: bits[1:0] are forced to 00.
  - mcause, mscratch, mcycle, minstret: full width.
  - Writes to RO or unmapped addresses are silently dropped.
- Trap (trap_en_i=1), one-cycle commit:
  - mepc<=trap_pc_i with [1:0]=0.
  - mcause<=trap_cause_i.
  - mstatus.MPIE<=MIE, MIE<=0, MPP<=11.
- mret (mret_en_i=1), one-cycle commit: mstatus.MIE<=MPIE, MPIE<=1, MPP<=11. mepc and mcause are unchanged.
- Priority within a cycle: trap > mret > csr_wen.
  - A CSR write in the same cycle as a trap or mret is dropped only for the registers that the event updates. A write to an unrelated CSR still commits.
  - trap_en_i and mret_en_i both high: the trap wins and mret is ignored.
- mcycle increments by 1 every non-reset cycle and wraps 2^64-1 -> 0. A CSR write to mcycle in that cycle takes precedence: the written value is loaded with no increment.
- minstret increments when retire_i=1 and wraps. A CSR write to minstret takes precedence over the increment.
- Latency: every update becomes visible on the outputs exactly one cycle after the commit edge. There are no multi-cycle operations and no stall outputs.

Test Plan:
- Reset, then read 0x300/0x305/0xF14 -> 64'h0000_000a_0000_1800 / 0 / 0. Read 0x7C0 -> rdata 0, illegal=1.
- csr_wen to 0x305 with 64'h8000_1003 -> next cycle mtvec_o=64'h8000_1000. Same-cycle read of 0x305 returns 0.
- mstatus.MIE=1, then trap_en with pc 64'h8000_0104 and cause 11 -> mepc_o=64'h8000_0104, mcause_o=11, mstatus MIE=0, MPIE=1, MPP=11. Follow with mret -> MIE=1, MPIE=1.
- trap_en, mret_en and csr_wen(0x341, 64'h1234) all in one cycle -> trap applied, mepc=trap_pc, mret ignored, write dropped. Repeat with csr_wen to 0x340 -> mscratch=64'h1234 committed alongside the trap.
- Write mcycle=64'hFFFF_FFFF_FFFF_FFFE -> reads ...FFFE, then ...FFFF, then 0 on consecutive cycles. retire_i pulsed 3 times plus one write to minstret=5 in the middle -> final minstret equals 5 plus the retires after the write.
- Assert rst mid-count while trap_en=1 -> all registers at reset values next cycle and the trap is discarded.
